// File: rtl/ballgame_pkg.sv
// ballgame_pkg: shared geometry constants and run-state encodings for the paddle game.
package ballgame_pkg;
    localparam int SCREEN_W = 640;
    localparam int PADDLE_W = 64;
    localparam int STEP = 16;
    localparam int X_W = 10;
    localparam logic [X_W-1:0] XMAX = X_W'(SCREEN_W - PADDLE_W);
    localparam logic [X_W-1:0] XCTR = XMAX / 2;
    localparam logic [X_W-1:0] XSTEP = X_W'(STEP);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;
endpackage

// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: key/frame/ball events into the paddle controller and paddle/state outputs back.
interface paddle_ctrl_if;
    import ballgame_pkg::*;
    logic key_start, user1_left, user1_right, user2_left, user2_right;
    logic frame_tick, game_over;
    logic [X_W-1:0] paddle1_x, paddle2_x;
    logic [2:0] state;
    logic serve, running;
    modport master (
        output key_start, user1_left, user1_right, user2_left, user2_right, frame_tick, game_over,
        input  paddle1_x, paddle2_x, state, serve, running
    );
    modport slave (
        input  key_start, user1_left, user1_right, user2_left, user2_right, frame_tick, game_over,
        output paddle1_x, paddle2_x, state, serve, running
    );
endinterface

// File: rtl/paddle_axis.sv
// paddle_axis: one player's buffered left/right move and clamped paddle position.
module paddle_axis
    import ballgame_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           left,
    input  logic           right,
    input  logic           capture_en,
    input  logic           apply_en,
    input  logic           center,
    output logic [X_W-1:0] x
);
    logic pend_l, pend_r, nxt_l, nxt_r;
    logic [X_W-1:0] x_nxt;
    // A fresh pulse always replaces pending, even on the tick that consumes the old one.
    always_comb begin
        nxt_l = capture_en && ((left || right) ? (left && !right) : (pend_l && !apply_en));
        nxt_r = capture_en && ((left || right) ? (right && !left) : (pend_r && !apply_en));
        x_nxt = center ? XCTR :
                !apply_en ? x :
                pend_l ? ((x < XSTEP) ? '0 : x - XSTEP) :
                pend_r ? ((x > XMAX - XSTEP) ? XMAX : x + XSTEP) : x;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
            x <= XCTR;
        end else begin
            pend_l <= nxt_l;
            pend_r <= nxt_r;
            x <= x_nxt;
        end
    end
endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: game run-state FSM plus two frame-synchronous paddle axes.
module paddle_ctrl
    import ballgame_pkg::*;
(
    input logic          clk,
    input logic          reset,
    paddle_ctrl_if.slave bus
);
    state_t st, nxt;
    logic serve_q, running_q, capture_en, apply_en, center;
    always_comb begin
        nxt = IDLE;
        case (st)
            IDLE:    nxt = bus.key_start ? SERVE : IDLE;
            SERVE:   nxt = bus.frame_tick ? PLAY : SERVE;
            PLAY:    nxt = bus.game_over ? OVER : bus.key_start ? PAUSE : PLAY;
            PAUSE:   nxt = bus.key_start ? PLAY : PAUSE;
            OVER:    nxt = bus.key_start ? IDLE : OVER;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            serve_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            st <= nxt;
            serve_q <= (st == SERVE) && bus.frame_tick;
            running_q <= (nxt == PLAY);
        end
    end
    // Centering keys off the next state so paddles read XCTR on the same edge IDLE is entered.
    assign capture_en = (st == SERVE) || (st == PLAY);
    assign apply_en = (st == PLAY) && bus.frame_tick;
    assign center = (nxt == IDLE);
    paddle_axis u_p1 (
        .clk(clk), .reset(reset), .left(bus.user1_left), .right(bus.user1_right),
        .capture_en(capture_en), .apply_en(apply_en), .center(center), .x(bus.paddle1_x)
    );
    paddle_axis u_p2 (
        .clk(clk), .reset(reset), .left(bus.user2_left), .right(bus.user2_right),
        .capture_en(capture_en), .apply_en(apply_en), .center(center), .x(bus.paddle2_x)
    );
    assign bus.state = st;
    assign bus.serve = serve_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed vectors with hand-computed expectations for paddle_ctrl.
module tb_paddle_ctrl;
    localparam int KS = 1, U1L = 2, U1R = 4, U2L = 8, U2R = 16, FT = 32, GO = 64;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int exp1, exp2;
    paddle_ctrl_if bus ();
    paddle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic cyc(input int v);
        bus.key_start = (v & KS) != 0;
        bus.user1_left = (v & U1L) != 0;
        bus.user1_right = (v & U1R) != 0;
        bus.user2_left = (v & U2L) != 0;
        bus.user2_right = (v & U2R) != 0;
        bus.frame_tick = (v & FT) != 0;
        bus.game_over = (v & GO) != 0;
        @(posedge clk);
        #1;
        {bus.key_start, bus.user1_left, bus.user1_right, bus.user2_left,
         bus.user2_right, bus.frame_tick, bus.game_over} = '0;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask
    initial begin
        cyc(0);
        cyc(0);
        reset = 1'b0;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_running", 32'(bus.running), 0);
        chk("rst_serve", 32'(bus.serve), 0);
        chk("rst_p1", 32'(bus.paddle1_x), 288);
        chk("rst_p2", 32'(bus.paddle2_x), 288);
        cyc(KS);
        chk("to_serve", 32'(bus.state), 1);
        cyc(FT);
        chk("to_play", 32'(bus.state), 2);
        chk("serve_pulse", 32'(bus.serve), 1);
        chk("running_play", 32'(bus.running), 1);
        chk("play_p1", 32'(bus.paddle1_x), 288);
        cyc(0);
        chk("serve_drop", 32'(bus.serve), 0);
        cyc(U1L);
        chk("no_move_before_tick", 32'(bus.paddle1_x), 288);
        cyc(FT);
        chk("p1_left1", 32'(bus.paddle1_x), 272);
        chk("p2_untouched", 32'(bus.paddle2_x), 288);
        for (int i = 0; i < 3; i++) begin
            cyc(U1L);
            cyc(FT);
        end
        chk("p1_left4", 32'(bus.paddle1_x), 224);
        exp2 = 288;
        for (int i = 0; i < 40; i++) begin
            cyc(U2R);
            cyc(FT);
            exp2 = (exp2 > 560) ? 576 : exp2 + 16;
            chk("p2_right_clamp", 32'(bus.paddle2_x), 32'(exp2));
        end
        exp1 = 224;
        for (int i = 0; i < 15; i++) begin
            cyc(U1L);
            cyc(FT);
            exp1 = (exp1 < 16) ? 0 : exp1 - 16;
            chk("p1_left_clamp", 32'(bus.paddle1_x), 32'(exp1));
        end
        cyc(U1R);
        cyc(U1L | U1R);
        cyc(FT);
        chk("cancel", 32'(bus.paddle1_x), 0);
        cyc(U1R);
        cyc(U1L);
        cyc(FT);
        chk("latest_wins", 32'(bus.paddle1_x), 0);
        cyc(U1R | FT);
        chk("press_on_tick_deferred", 32'(bus.paddle1_x), 0);
        cyc(FT);
        chk("press_on_tick_applied", 32'(bus.paddle1_x), 16);
        cyc(FT);
        chk("one_step_per_press", 32'(bus.paddle1_x), 16);
        cyc(U1R | U2L);
        cyc(FT);
        chk("both_p1", 32'(bus.paddle1_x), 32);
        chk("both_p2", 32'(bus.paddle2_x), 560);
        cyc(KS);
        chk("pause_state", 32'(bus.state), 3);
        chk("pause_running", 32'(bus.running), 0);
        cyc(GO);
        chk("go_ignored_pause", 32'(bus.state), 3);
        cyc(U1R);
        cyc(FT);
        cyc(U2L | FT);
        chk("pause_p1_frozen", 32'(bus.paddle1_x), 32);
        chk("pause_p2_frozen", 32'(bus.paddle2_x), 560);
        cyc(KS);
        chk("resume_state", 32'(bus.state), 2);
        chk("resume_no_serve", 32'(bus.serve), 0);
        chk("resume_running", 32'(bus.running), 1);
        cyc(FT);
        chk("pause_pending_dropped", 32'(bus.paddle1_x), 32);
        cyc(KS | GO);
        chk("go_beats_start", 32'(bus.state), 4);
        chk("over_running", 32'(bus.running), 0);
        cyc(U1R);
        cyc(FT);
        chk("over_frozen", 32'(bus.paddle1_x), 32);
        cyc(KS);
        chk("over_to_idle", 32'(bus.state), 0);
        chk("idle_p1_center", 32'(bus.paddle1_x), 288);
        chk("idle_p2_center", 32'(bus.paddle2_x), 288);
        cyc(KS);
        cyc(U2L);
        cyc(FT);
        chk("serve_pend_held", 32'(bus.paddle2_x), 288);
        chk("serve_pulse2", 32'(bus.serve), 1);
        cyc(FT);
        chk("serve_pend_applied", 32'(bus.paddle2_x), 272);
        for (int i = 0; i < 7; i++) begin
            cyc(U1R);
            cyc(FT);
        end
        chk("p1_at_400", 32'(bus.paddle1_x), 400);
        cyc(U1R);
        reset = 1'b1;
        cyc(FT);
        reset = 1'b0;
        chk("midplay_rst_state", 32'(bus.state), 0);
        chk("midplay_rst_p1", 32'(bus.paddle1_x), 288);
        chk("midplay_rst_p2", 32'(bus.paddle2_x), 288);
        chk("midplay_rst_running", 32'(bus.running), 0);
        cyc(KS);
        cyc(FT);
        cyc(FT);
        chk("rst_pending_cleared", 32'(bus.paddle1_x), 288);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
